// File: rtl/uart_loader_if.sv
// Boot-loader bus bundle: UART byte input, instruction-memory write port and CPU byte FIFO port.
// master = loader side, slave = receiver/memory/CPU side.
interface uart_loader_if #(
  parameter int ADDR_WIDTH = 15
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  load_done;
  logic                  error;
  logic                  cpu_rd;
  logic [7:0]            cpu_data;
  logic                  cpu_empty;
  logic                  overrun;

  modport master (
    input  rx_data, rx_valid, cpu_rd,
    output imem_we, imem_addr, imem_wdata, load_done, error, cpu_data, cpu_empty, overrun
  );

  modport slave (
    output rx_data, rx_valid, cpu_rd,
    input  imem_we, imem_addr, imem_wdata, load_done, error, cpu_data, cpu_empty, overrun
  );
endinterface

// File: rtl/uart_loader.sv
// Boot loader: parses a big-endian word-count header, writes N words to imem, then feeds a FWFT byte FIFO.
// Optional trailing XOR checksum byte enabled by UART_LOADER_CHECKSUM_EN.
module uart_loader #(
  parameter int ADDR_WIDTH     = 15,
  parameter int FIFO_DEPTH_LOG = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  uart_loader_if.master bus
);
  localparam int                      DEPTH     = 1 << FIFO_DEPTH_LOG;
  localparam logic [32:0]             MAX_WORDS = 33'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]     WCNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [FIFO_DEPTH_LOG-1:0] PTR_ONE = FIFO_DEPTH_LOG'(1);
  localparam logic [FIFO_DEPTH_LOG:0] CNT_ONE   = (FIFO_DEPTH_LOG+1)'(1);
  localparam logic [FIFO_DEPTH_LOG:0] FULL_CNT  = (FIFO_DEPTH_LOG+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_HDR,
    ST_DATA,
`ifdef UART_LOADER_CHECKSUM_EN
    ST_CHK,
`endif
    ST_RUN,
    ST_ERR
  } state_t;

  state_t                  r_state, w_next;
  logic [1:0]              r_lane;
  logic [23:0]             r_shift;
  logic [ADDR_WIDTH:0]     r_nw, r_wcnt;
  logic                    r_we, r_done;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [31:0]             r_wdata;
  logic [31:0]             w_word;
  logic                    w_loading, w_last_byte, w_last_word, w_hdr_bad, w_hdr_zero, w_done_set;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]              r_xor;
  logic                    w_xor_ok;
  assign w_xor_ok = (bus.rx_data == r_xor);
`endif

  assign w_word      = {r_shift, bus.rx_data};
  assign w_loading   = (r_state == ST_HDR) || (r_state == ST_DATA)
`ifdef UART_LOADER_CHECKSUM_EN
                       || (r_state == ST_CHK)
`endif
                       ;
  assign w_last_byte = bus.rx_valid && (r_lane == 2'd3);
  assign w_last_word = ((r_wcnt + WCNT_ONE) == r_nw);
  assign w_hdr_bad   = ({1'b0, w_word} > MAX_WORDS);
  assign w_hdr_zero  = (w_word == 32'd0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_HDR;
    else        r_state <= w_next;
  end

  // load_done is set directly on the transition only where it must rise the cycle after the last byte
  always_comb begin
    w_next     = r_state;
    w_done_set = 1'b0;
    case (r_state)
      ST_HDR: if (w_last_byte) begin
        if (w_hdr_bad) w_next = ST_ERR;
        else if (w_hdr_zero) begin
`ifdef UART_LOADER_CHECKSUM_EN
          w_next = ST_CHK;
`else
          w_next     = ST_RUN;
          w_done_set = 1'b1;
`endif
        end else w_next = ST_DATA;
      end
      ST_DATA: if (w_last_byte && w_last_word) begin
`ifdef UART_LOADER_CHECKSUM_EN
        w_next = ST_CHK;
`else
        w_next = ST_RUN;
`endif
      end
`ifdef UART_LOADER_CHECKSUM_EN
      ST_CHK: if (bus.rx_valid) begin
        if (w_xor_ok) begin
          w_next     = ST_RUN;
          w_done_set = 1'b1;
        end else w_next = ST_ERR;
      end
`endif
      ST_RUN:  w_next = ST_RUN;
      default: w_next = ST_ERR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_lane  <= '0;
      r_shift <= '0;
      r_nw    <= '0;
      r_wcnt  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      r_xor   <= '0;
`endif
    end else begin
      r_we   <= 1'b0;
      r_done <= r_done | w_done_set | (r_state == ST_RUN);
      if (w_loading && bus.rx_valid) begin
        r_lane  <= r_lane + 2'd1;
        r_shift <= w_word[23:0];
`ifdef UART_LOADER_CHECKSUM_EN
        r_xor   <= r_xor ^ bus.rx_data;
`endif
      end
      if (r_state == ST_HDR && w_last_byte && !w_hdr_bad) begin
        r_nw   <= w_word[ADDR_WIDTH:0];
        r_wcnt <= '0;
      end
      if (r_state == ST_DATA && w_last_byte) begin
        r_we    <= 1'b1;
        r_addr  <= r_wcnt[ADDR_WIDTH-1:0];
        r_wdata <= w_word;
        r_wcnt  <= r_wcnt + WCNT_ONE;
      end
    end
  end

  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign bus.load_done  = r_done;
  assign bus.error      = (r_state == ST_ERR);

  // CPU byte FIFO, first-word-fall-through; a pop frees room for a push in the same cycle
  logic [7:0]                r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG-1:0] r_wp, r_rp;
  logic [FIFO_DEPTH_LOG:0]   r_cnt;
  logic                      r_ovr;
  logic                      w_run, w_empty, w_full, w_pop, w_push;

  assign w_run   = (r_state == ST_RUN);
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_pop   = w_run && bus.cpu_rd && !w_empty;
  assign w_push  = w_run && bus.rx_valid && (!w_full || w_pop);

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wp] <= bus.rx_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovr <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_ONE;
      if (w_pop)  r_rp <= r_rp + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_ONE;
        2'b01:   r_cnt <= r_cnt - CNT_ONE;
        default: r_cnt <= r_cnt;
      endcase
      if (w_run && bus.rx_valid && w_full && !w_pop) r_ovr <= 1'b1;
    end
  end

  assign bus.cpu_empty = w_empty;
  assign bus.cpu_data  = w_empty ? 8'h00 : r_mem[r_rp];
  assign bus.overrun   = r_ovr;
endmodule

// File: tb/tb_uart_loader.sv
// Directed + randomized bench for uart_loader; expectations come from a byte-stream/queue model.
module tb_uart_loader;
  localparam int AW    = 15;
  localparam int FL    = 4;
  localparam int DEPTH = 1 << FL;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_loader_if #(.ADDR_WIDTH(AW)) bus();
  uart_loader #(.ADDR_WIDTH(AW), .FIFO_DEPTH_LOG(FL)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int         n_chk = 0;
  int         n_err = 0;
  wr_t        seen[$];
  logic [7:0] fq[$];
  bit         fovr;

  always @(negedge clk) if (bus.imem_we === 1'b1) seen.push_back(wr_t'{bus.imem_addr, bus.imem_wdata});

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.cpu_rd   = 1'b0;
    idle(2);
    seen.delete();
    fq.delete();
    fovr  = 1'b0;
    rst_n = 1'b1;
    idle(1);
  endtask

  // Boot stream as the loader sees it: header, words MSB first, optional XOR byte.
  function automatic void build(input logic [31:0] n, input logic [31:0] w[$], output logic [7:0] s[$]);
    logic [7:0] x;
    s = {};
    x = 8'h00;
    for (int k = 3; k >= 0; k--) begin s.push_back(n[8*k +: 8]); x ^= n[8*k +: 8]; end
    foreach (w[i]) for (int k = 3; k >= 0; k--) begin s.push_back(w[i][8*k +: 8]); x ^= w[i][8*k +: 8]; end
`ifdef UART_LOADER_CHECKSUM_EN
    s.push_back(x);
`endif
  endfunction

  task automatic do_load(input string tag, input logic [31:0] w[$], input bit gaps);
    logic [7:0] s[$];
    int lag;
    build(32'(w.size()), w, s);
    seen.delete();
    foreach (s[i]) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(s[i]);
    end
`ifdef UART_LOADER_CHECKSUM_EN
    lag = 1;
`else
    lag = (w.size() == 0) ? 1 : 2;
`endif
    if (lag == 2) begin
      check({tag, ".we_last"}, bus.imem_we, 1'b1);
      check({tag, ".done_early"}, bus.load_done, 1'b0);
      idle(1);
    end
    check({tag, ".done"}, bus.load_done, 1'b1);
    check({tag, ".error"}, bus.error, 1'b0);
    check({tag, ".cpu_empty"}, bus.cpu_empty, 1'b1);
    check({tag, ".nwrites"}, seen.size(), w.size());
    foreach (w[i]) if (i < seen.size()) begin
      check({tag, ".addr"}, seen[i].addr, i);
      check({tag, ".data"}, seen[i].data, w[i]);
    end
  endtask

  // One RUN-state cycle of push/pop against the queue model, then compare the FIFO outputs.
  task automatic step(input bit p, input logic [7:0] b, input bit r);
    bit pop_ok;
    bus.rx_valid = p;
    bus.rx_data  = b;
    bus.cpu_rd   = r;
    pop_ok = r && (fq.size() > 0);
    if (pop_ok) void'(fq.pop_front());
    if (p) begin
      if (fq.size() < DEPTH) fq.push_back(b);
      else fovr = 1'b1;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.cpu_rd   = 1'b0;
    check("fifo.empty", bus.cpu_empty, fq.size() == 0);
    check("fifo.data", bus.cpu_data, (fq.size() > 0) ? fq[0] : 8'h00);
    check("fifo.overrun", bus.overrun, fovr);
  endtask

  initial begin
    logic [31:0] w[$];
    int          k;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.cpu_rd   = 1'b0;
    reset_dut();

    check("rst.imem_we", bus.imem_we, 1'b0);
    check("rst.imem_addr", bus.imem_addr, 0);
    check("rst.imem_wdata", bus.imem_wdata, 0);
    check("rst.load_done", bus.load_done, 1'b0);
    check("rst.error", bus.error, 1'b0);
    check("rst.overrun", bus.overrun, 1'b0);
    check("rst.cpu_empty", bus.cpu_empty, 1'b1);
    check("rst.cpu_data", bus.cpu_data, 8'h00);

    w = '{32'hDEADBEEF, 32'h01020304};
    do_load("two_words", w, 1'b0);

    reset_dut();
    w = {};
    do_load("zero_words", w, 1'b0);
    step(1'b1, 8'h41, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    reset_dut();
    send(8'h00); send(8'h00); send(8'h80); send(8'h01);
    check("hdr_big.error", bus.error, 1'b1);
    check("hdr_big.done", bus.load_done, 1'b0);
    for (int i = 0; i < 8; i++) begin bus.cpu_rd = 1'b1; send(8'(i * 37)); end
    bus.cpu_rd = 1'b0;
    idle(1);
    check("hdr_big.nwrites", seen.size(), 0);
    check("hdr_big.cpu_empty", bus.cpu_empty, 1'b1);
    check("hdr_big.error_sticky", bus.error, 1'b1);
    check("hdr_big.done_low", bus.load_done, 1'b0);

    reset_dut();
    send(8'h00); send(8'h00); send(8'h80); send(8'h00);
    idle(1);
    check("hdr_max.error", bus.error, 1'b0);
    check("hdr_max.done", bus.load_done, 1'b0);

    reset_dut();
    w = {};
    do_load("ovr_setup", w, 1'b0);
    for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    check("ovr.flag", bus.overrun, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b1);

    reset_dut();
    w = {};
    do_load("full_pp_setup", w, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
    check("full_pp.overrun", bus.overrun, 1'b0);
    k = 0;
    while (bus.cpu_empty === 1'b0 && k < 40) begin step(1'b0, 8'h00, 1'b1); k++; end
    check("full_pp.drain_count", k, 16);

    reset_dut();
    send(8'h00); send(8'h00); send(8'h00); send(8'h02);
    for (int i = 0; i < 6; i++) send(8'(8'hA0 + i));
    rst_n = 1'b0;
    #1;
    check("midrst.done", bus.load_done, 1'b0);
    check("midrst.we", bus.imem_we, 1'b0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    w = '{32'hCAFEF00D};
    do_load("after_midrst", w, 1'b0);

    for (int t = 0; t < 4; t++) begin
      reset_dut();
      w = {};
      for (int i = 0, n = $urandom_range(1, 6); i < n; i++) w.push_back($urandom);
      do_load("rand_load", w, 1'b1);
    end

    reset_dut();
    w = {};
    do_load("rand_fifo_setup", w, 1'b0);
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 9) < 6), 8'($urandom), ($urandom_range(0, 9) < 4));

`ifdef UART_LOADER_CHECKSUM_EN
    reset_dut();
    send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h45);
    check("chk_good.done", bus.load_done, 1'b1);
    check("chk_good.error", bus.error, 1'b0);
    reset_dut();
    send(8'h00); send(8'h00); send(8'h00); send(8'h01);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'h00);
    check("chk_bad.error", bus.error, 1'b1);
    check("chk_bad.done", bus.load_done, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_loader.md
Name: uart_loader

Overview:
Sits between the UART byte receiver and the core. Sequences the boot load by parsing a word-count header from the incoming byte stream. Assembles big-endian 32-bit words and writes them to instruction memory starting at address 0. After the load it hands the receiver over to the CPU through a small first-word-fall-through byte FIFO.

Parameters:
ADDR_WIDTH, 15, instruction-memory word-address width; max program = 2**ADDR_WIDTH words
FIFO_DEPTH_LOG, 4, log2 of CPU byte FIFO depth (default 16 entries)

Ports:
CLK  input  1  system clock, all state on rising edge
RST_N  input  1  asynchronous active-low reset
rx_data  input  8  byte from UART receiver, valid only while rx_valid=1
rx_valid  input  1  single-cycle strobe, one per received byte
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word address for imem_we
imem_wdata  output  32  word data for imem_we
load_done  output  1  high once load is complete; core held until then
error  output  1  sticky, header out of range (or checksum mismatch, see option)
cpu_rd  input  1  CPU pops head of FIFO
cpu_data  output  8  FIFO head byte, valid while cpu_empty=0
cpu_empty  output  1  FIFO empty
overrun  output  1  sticky, a byte was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock (CLK); RST_N asynchronous active-low.
- Reset values: state=HDR, all counters 0, FIFO empty. Outputs: imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, error=0, overrun=0, cpu_empty=1, cpu_data=0.
- States: HDR, DATA, (CHK), RUN, ERR.
- Byte lane counter: 2 bits. It advances only on rx_valid in HDR/DATA/CHK and wraps 3->0. Bytes are shifted in MSB first (big-endian).
- HDR: collects 4 bytes into 32-bit N.
  - On the 4th byte, if N > 2**ADDR_WIDTH -> ERR.
  - Else if N=0 -> RUN, or CHK with the option.
  - Else -> DATA with word counter=0.
- DATA: on the 4th byte of each word, imem_we=1 on the next cycle. imem_addr = word counter and imem_wdata = assembled word, both registered. The word counter (ADDR_WIDTH+1 bits) then increments. After word N-1 is written -> RUN (or CHK).
- Load latency: 4th byte at cycle t -> imem_we at t+1.
- RUN: load_done=1 from the cycle after the last imem_we; for N=0, the cycle after the 4th header byte. Remains 1 until reset.
  - Every rx_valid pushes rx_data into the FIFO.
  - A byte pushed at cycle t gives cpu_empty=0 at t+1.
- FIFO rules:
  - cpu_rd while empty is ignored.
  - Push while full with no pop: byte dropped, overrun set (sticky until reset).
  - Push and pop in the same cycle while full: both accepted, occupancy unchanged, overrun not set.
  - Push and pop in the same cycle while non-empty: occupancy unchanged.
  - Pointers wrap modulo 2**FIFO_DEPTH_LOG.
- ERR: error=1, load_done=0. All further rx_valid ignored, imem_we never asserted. Exit only by reset.
- Outside RUN: FIFO is not written; cpu_rd is ignored.
- Reset mid-load: returns to HDR immediately (asynchronous), partial word discarded. Memory already written is not cleared.
- imem_we is never asserted outside DATA.

Optional Feature:
UART_LOADER_CHECKSUM_EN
- Defined: the stream carries one extra byte after the last data word (after the header when N=0). That byte is the XOR of all 4 header bytes and all 4N data bytes.
  - The CHK state compares it against the running XOR.
  - Match -> RUN, load_done set the next cycle.
  - Mismatch -> ERR.
- Undefined: no CHK state and no running XOR; DATA goes directly to RUN.

Test Plan:
- Header 00 00 00 02, then DE AD BE EF 01 02 03 04 -> imem_we twice: addr 0 = 0xDEADBEEF, addr 1 = 0x01020304. load_done rises the cycle after the second imem_we.
- Header 00 00 00 00 -> no imem_we, load_done=1 one cycle after the 4th byte. Then byte 0x41 -> cpu_empty=0 next cycle, cpu_data=0x41. cpu_rd -> cpu_empty=1.
- Header 00 00 80 01 with ADDR_WIDTH=15 -> error=1, load_done=0. Following bytes cause no imem_we and no FIFO activity.
- In RUN, 17 bytes 0x00..0x10 pushed with no cpu_rd (depth 16) -> overrun=1. Pops return 0x00..0x0F, then cpu_empty=1. Next, full FIFO plus simultaneous push and pop -> overrun stays 0 after a reset, occupancy stays 16.
- RST_N pulsed low after 6 of 8 data bytes -> state HDR, load_done=0. A fresh header 00 00 00 01 + 4 bytes loads addr 0 correctly.
- With UART_LOADER_CHECKSUM_EN: header 00 00 00 01, data 11 22 33 44, checksum 0x45 -> load_done=1. Checksum 0x00 instead -> error=1.
